johnson_decoder_monitor: RTL and testbench
==========================================

Name: johnson_decoder_monitor

Overview:
- Receiving end of the Johnson counter interface: samples an N-bit Johnson code each valid cycle and decodes it to a binary state index.
- Checks that each code is legal and is the correct successor of the previous one. Reports lock status and a saturating error count.
- Sits downstream of a Johnson counter or any twisted-ring source, e.g. for sequencer or timing-generator health monitoring.

Parameters:
- N, 4, Johnson code width; the ring has 2N states.
- CW, 3, decoded index width; must equal clog2(2N).
- LOCK_LEN, 2, number of consecutive correctly sequenced legal samples required to enter LOCKED.
- ALLOW_HOLD, 1, 1 = a repeat of the previous code is accepted (source paused); 0 = a repeat is a sequence error.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  code is sampled when high
- code  in  N  Johnson code from source
- clear_err  in  1  synchronous clear of err_cnt
- index  out  CW  decoded state index 0..2N-1
- index_valid  out  1  one-cycle pulse per accepted legal sample
- illegal  out  1  one-cycle pulse: sampled code is not a Johnson code
- seq_err  out  1  one-cycle pulse: legal code but wrong successor while LOCKED
- locked  out  1  high in LOCKED state
- err_cnt  out  8  saturating count of illegal + seq_err events

Behaviour:
- Reset (reset=0, asynchronous):
  - index=0, index_valid=0, illegal=0, seq_err=0, locked=0, err_cnt=0.
  - State=UNLOCKED, run length=0, no previous code held.
  - Asserting reset mid-stream discards all history immediately.
- Latency: all outputs are registered and reflect the sample taken on the previous clock edge (1 cycle). Pulses last exactly one cycle. With in_valid=0, all pulses are 0 and index holds.
- Legal codes (N=4): the 2N-code ring 0000→1000→1100→1110→1111→0111→0011→0001→0000. Successor = {~code[0], code[N-1:1]}.
- Decode rule, with k = popcount(code):
  - code=0 → index 0
  - MSB=1 → index k
  - MSB=0 and code≠0 → index 2N−k
  - Legal iff the ones are contiguous and touch the MSB or the LSB, or the code is 0.
- Illegal sample:
  - illegal=1, index_valid=0, index holds its old value.
  - err_cnt increments. State→UNLOCKED, run length=0, previous code invalidated.
- Legal sample with no previous code held: index_valid=1, run length=1, code stored. No sequence check is made.
- Legal sample with a previous code held:
  - Code is the expected successor: index_valid=1, run length+1 (saturating at LOCK_LEN).
  - Code equals previous and ALLOW_HOLD=1: index_valid=1, run length unchanged, no error.
  - Any other code (including a repeat when ALLOW_HOLD=0):
    - In LOCKED: seq_err=1, err_cnt increments, state→UNLOCKED.
    - In UNLOCKED: no flag, no count.
    - In both cases index_valid=1, the code becomes the new reference, and run length=1.
- FSM:
  - UNLOCKED→LOCKED on the edge where run length reaches LOCK_LEN; locked rises together with that sample's index_valid.
  - LOCKED→UNLOCKED on illegal or seq_err; locked falls together with the error pulse.
- Wrap-around: 0001→0000 is a valid successor. Index goes 7→0 with no error.
- err_cnt: 8-bit, saturates at 255 with no wrap.
- clear_err has priority over a simultaneous error: err_cnt loads 0, but the error pulse still asserts.

Test Plan:
- Reset, then feed 0000,1000,1100 with in_valid=1 → index 0,1,2 one cycle later; locked=1 from the 2nd sample onward; no errors.
- Locked, full ring twice including 0001→0000 → index 0..7,0..7; seq_err never asserts; err_cnt=0.
- Locked at 1110, feed 1010 → illegal=1, locked=0, err_cnt=1, index stays 3; then 1111,0111 → relock, index 4,5.
- Locked at 1100, feed 0011 (skip) → seq_err=1, err_cnt+1, locked=0; then 0001,0000 → locked=1 again.
- ALLOW_HOLD=1: repeat 1111 three times → index 4 each time, no errors. ALLOW_HOLD=0: same stimulus → seq_err on the 2nd sample.
- Force 300 illegal samples → err_cnt=255. Assert clear_err together with an illegal sample → err_cnt=0, illegal=1. Pull reset low mid-run → all outputs 0 asynchronously.

Source files
------------

// File: rtl/johnson_decoder_monitor.sv
// Purpose : decode an N-bit Johnson (twisted-ring) code to its state index and
//           monitor that the stream is legal and correctly sequenced.
// Latency : 1 cycle; every output is registered from the sample of the previous edge.
// Backpr. : none; a sample is taken on every cycle in which in_valid is high.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous, active-low reset
//   in_valid     code is sampled when high
//   code[N-1:0]  Johnson code from the source
//   clear_err    synchronous clear of err_cnt (wins over a same-cycle error)
//   index        decoded state index 0..2N-1, holds when no legal sample
//   index_valid  one-cycle pulse per accepted legal sample
//   illegal      one-cycle pulse, sampled code is not a Johnson code
//   seq_err      one-cycle pulse, legal code but wrong successor while locked
//   locked       high while in the LOCKED state
//   err_cnt      saturating count of illegal + seq_err events
module johnson_decoder_monitor #(
  parameter int N          = 4,
  parameter int CW         = 3,
  parameter int LOCK_LEN   = 2,
  parameter int ALLOW_HOLD = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [N-1:0]  code,
  input  logic          clear_err,
  output logic [CW-1:0] index,
  output logic          index_valid,
  output logic          illegal,
  output logic          seq_err,
  output logic          locked,
  output logic [7:0]    err_cnt
);

  localparam int RW = $clog2(LOCK_LEN + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(LOCK_LEN);
  // 2N may equal 2**CW and truncate to zero; the subtraction below is modulo
  // 2**CW, so (2N - k) still comes out right.
  localparam logic [CW-1:0] RING_LEN = CW'(2 * N);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] run_q, run_d;
  logic [N-1:0]  prev_q, prev_d;
  logic          prev_vld_q, prev_vld_d;
  logic [CW-1:0] index_d;
  logic          index_valid_d, illegal_d, seq_err_d, err_evt;

  logic [CW-1:0] ones;
  logic [CW-1:0] edges;
  logic [CW-1:0] dec;
  logic          legal;
  logic [N-1:0]  succ;

  // A Johnson code is a single run of ones anchored at one end, which is the
  // same as having at most one 0/1 boundary between adjacent bits.
  always_comb begin
    ones  = '0;
    edges = '0;
    for (int i = 0; i < N; i++) begin
      ones = ones + CW'(code[i]);
    end
    for (int i = 0; i < N - 1; i++) begin
      edges = edges + CW'(code[i] ^ code[i+1]);
    end
    legal = (edges <= CW'(1));

    if (code == '0) begin
      dec = '0;
    end else if (code[N-1]) begin
      dec = ones;
    end else begin
      dec = RING_LEN - ones;
    end
  end

  assign succ = {~prev_q[0], prev_q[N-1:1]};

  always_comb begin
    state_d       = state_q;
    run_d         = run_q;
    prev_d        = prev_q;
    prev_vld_d    = prev_vld_q;
    index_d       = index;
    index_valid_d = 1'b0;
    illegal_d     = 1'b0;
    seq_err_d     = 1'b0;
    err_evt       = 1'b0;

    if (in_valid) begin
      if (!legal) begin
        illegal_d  = 1'b1;
        err_evt    = 1'b1;
        state_d    = UNLOCKED;
        run_d      = '0;
        prev_vld_d = 1'b0;
      end else begin
        index_d       = dec;
        index_valid_d = 1'b1;
        prev_d        = code;
        prev_vld_d    = 1'b1;

        if (!prev_vld_q) begin
          run_d = RW'(1);
        end else if (code == succ) begin
          run_d = (run_q >= RUN_MAX) ? RUN_MAX : run_q + RW'(1);
        end else if ((code == prev_q) && (ALLOW_HOLD != 0)) begin
          run_d = run_q;
        end else begin
          // Out-of-sequence code becomes the new reference; only flagged if
          // we had already trusted the stream.
          run_d = RW'(1);
          if (state_q == LOCKED) begin
            seq_err_d = 1'b1;
            err_evt   = 1'b1;
          end
        end

        if (seq_err_d) begin
          state_d = UNLOCKED;
        end else if (run_d >= RUN_MAX) begin
          state_d = LOCKED;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= UNLOCKED;
      run_q       <= '0;
      prev_q      <= '0;
      prev_vld_q  <= 1'b0;
      index       <= '0;
      index_valid <= 1'b0;
      illegal     <= 1'b0;
      seq_err     <= 1'b0;
      err_cnt     <= '0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      prev_q      <= prev_d;
      prev_vld_q  <= prev_vld_d;
      index       <= index_d;
      index_valid <= index_valid_d;
      illegal     <= illegal_d;
      seq_err     <= seq_err_d;
      if (clear_err) begin
        err_cnt <= '0;
      end else if (err_evt && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

  assign locked = (state_q == LOCKED);

endmodule

// File: tb/tb_johnson_decoder_monitor.sv
module tb_johnson_decoder_monitor;

  localparam int N        = 4;
  localparam int CW       = 3;
  localparam int LOCK_LEN = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [N-1:0]  code;
  logic          clear_err;

  logic [CW-1:0] idx_h, idx_n;
  logic          iv_h, iv_n, ill_h, ill_n, se_h, se_n, lk_h, lk_n;
  logic [7:0]    cnt_h, cnt_n;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  johnson_decoder_monitor #(.N(N), .CW(CW), .LOCK_LEN(LOCK_LEN), .ALLOW_HOLD(1)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .code(code),
    .clear_err(clear_err), .index(idx_h), .index_valid(iv_h), .illegal(ill_h),
    .seq_err(se_h), .locked(lk_h), .err_cnt(cnt_h)
  );

  johnson_decoder_monitor #(.N(N), .CW(CW), .LOCK_LEN(LOCK_LEN), .ALLOW_HOLD(0)) dut_nh (
    .clock(clock), .reset(reset), .in_valid(in_valid), .code(code),
    .clear_err(clear_err), .index(idx_n), .index_valid(iv_n), .illegal(ill_n),
    .seq_err(se_n), .locked(lk_n), .err_cnt(cnt_n)
  );

  // Reference model: tracks ring positions rather than codes.
  typedef struct {
    int idx;
    bit iv;
    bit ill;
    bit se;
    bit lk;
    int cnt;
    int run;
    bit have_prev;
    int prev_pos;
  } model_t;

  model_t m_h, m_n;

  // Ring code for state i: i ones shifted in from the MSB, then drained.
  function automatic logic [N-1:0] jcode(input int i);
    int mask;
    mask = (1 << N) - 1;
    if (i <= N) return N'(mask ^ (mask >> i));
    else        return N'((1 << (2 * N - i)) - 1);
  endfunction

  function automatic int find_pos(input logic [N-1:0] c);
    for (int i = 0; i < 2 * N; i++) begin
      if (jcode(i) == c) return i;
    end
    return -1;
  endfunction

  function automatic model_t step(input model_t m, input bit hold, input bit v,
                                  input logic [N-1:0] c, input bit clr);
    model_t n;
    int p;
    bit err;
    n = m;
    n.iv = 0; n.ill = 0; n.se = 0;
    err = 0;
    p = find_pos(c);
    if (v) begin
      if (p < 0) begin
        n.ill = 1; err = 1; n.lk = 0; n.run = 0; n.have_prev = 0;
      end else begin
        n.idx = p; n.iv = 1;
        if (!m.have_prev) n.run = 1;
        else if (p == (m.prev_pos + 1) % (2 * N)) n.run = (m.run + 1 > LOCK_LEN) ? LOCK_LEN : m.run + 1;
        else if (p == m.prev_pos && hold) n.run = m.run;
        else begin
          n.run = 1;
          if (m.lk) begin n.se = 1; err = 1; end
        end
        if (n.se) n.lk = 0;
        else if (n.run >= LOCK_LEN) n.lk = 1;
        n.have_prev = 1; n.prev_pos = p;
      end
    end
    if (clr) n.cnt = 0;
    else if (err && n.cnt < 255) n.cnt = n.cnt + 1;
    return n;
  endfunction

  function automatic model_t model_reset();
    model_t m;
    m.idx = 0; m.iv = 0; m.ill = 0; m.se = 0; m.lk = 0;
    m.cnt = 0; m.run = 0; m.have_prev = 0; m.prev_pos = 0;
    return m;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_models();
    chk("h.index", int'(idx_h), m_h.idx);
    chk("h.index_valid", int'(iv_h), int'(m_h.iv));
    chk("h.illegal", int'(ill_h), int'(m_h.ill));
    chk("h.seq_err", int'(se_h), int'(m_h.se));
    chk("h.locked", int'(lk_h), int'(m_h.lk));
    chk("h.err_cnt", int'(cnt_h), m_h.cnt);
    chk("n.index", int'(idx_n), m_n.idx);
    chk("n.index_valid", int'(iv_n), int'(m_n.iv));
    chk("n.illegal", int'(ill_n), int'(m_n.ill));
    chk("n.seq_err", int'(se_n), int'(m_n.se));
    chk("n.locked", int'(lk_n), int'(m_n.lk));
    chk("n.err_cnt", int'(cnt_n), m_n.cnt);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".index"}, int'(idx_h), 0);
    chk({tag, ".index_valid"}, int'(iv_h), 0);
    chk({tag, ".illegal"}, int'(ill_h), 0);
    chk({tag, ".seq_err"}, int'(se_h), 0);
    chk({tag, ".locked"}, int'(lk_h), 0);
    chk({tag, ".err_cnt"}, int'(cnt_h), 0);
    chk({tag, ".n_locked"}, int'(lk_n), 0);
    chk({tag, ".n_err_cnt"}, int'(cnt_n), 0);
  endtask

  // One sample: drive on the falling edge, update the models on the rising
  // edge, compare 1 time unit later.
  task automatic cycle(input bit v, input logic [N-1:0] c, input bit clr);
    @(negedge clock);
    in_valid  = v;
    code      = c;
    clear_err = clr;
    @(posedge clock);
    m_h = step(m_h, 1'b1, v, c, clr);
    m_n = step(m_n, 1'b0, v, c, clr);
    #1;
    chk_models();
  endtask

  typedef struct {
    bit           v;
    logic [N-1:0] c;
    bit           clr;
    int           idx;
    bit           iv;
    bit           ill;
    bit           se;
    bit           lk;
    int           cnt;
  } vec_t;

  vec_t vecs[20];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int gpos;
    bit v;
    bit clr;
    logic [N-1:0] c;

    //            v  code     clr idx iv ill se lk cnt
    vecs[0]  = '{1, 4'b0000, 0, 0, 1, 0, 0, 0, 0};
    vecs[1]  = '{1, 4'b1000, 0, 1, 1, 0, 0, 1, 0};
    vecs[2]  = '{1, 4'b1100, 0, 2, 1, 0, 0, 1, 0};
    vecs[3]  = '{1, 4'b1110, 0, 3, 1, 0, 0, 1, 0};
    vecs[4]  = '{1, 4'b1010, 0, 3, 0, 1, 0, 0, 1};
    vecs[5]  = '{1, 4'b1111, 0, 4, 1, 0, 0, 0, 1};
    vecs[6]  = '{1, 4'b0111, 0, 5, 1, 0, 0, 1, 1};
    vecs[7]  = '{1, 4'b0011, 0, 6, 1, 0, 0, 1, 1};
    vecs[8]  = '{1, 4'b0011, 0, 6, 1, 0, 0, 1, 1};
    vecs[9]  = '{0, 4'b1010, 0, 6, 0, 0, 0, 1, 1};
    vecs[10] = '{1, 4'b0001, 0, 7, 1, 0, 0, 1, 1};
    vecs[11] = '{1, 4'b0000, 0, 0, 1, 0, 0, 1, 1};
    vecs[12] = '{1, 4'b1000, 0, 1, 1, 0, 0, 1, 1};
    vecs[13] = '{1, 4'b1100, 0, 2, 1, 0, 0, 1, 1};
    vecs[14] = '{1, 4'b0011, 0, 6, 1, 0, 1, 0, 2};
    vecs[15] = '{1, 4'b0001, 0, 7, 1, 0, 0, 1, 2};
    vecs[16] = '{1, 4'b0000, 0, 0, 1, 0, 0, 1, 2};
    vecs[17] = '{1, 4'b1010, 1, 0, 0, 1, 0, 0, 0};
    vecs[18] = '{1, 4'b1111, 0, 4, 1, 0, 0, 0, 0};
    vecs[19] = '{1, 4'b1111, 0, 4, 1, 0, 0, 0, 0};

    reset = 1'b0; in_valid = 1'b0; code = '0; clear_err = 1'b0;
    m_h = model_reset();
    m_n = model_reset();
    #12;
    chk_all_zero("reset");
    @(negedge clock);
    reset = 1'b1;

    // Directed table against hand-derived values (hold-enabled instance).
    for (int i = 0; i < 20; i++) begin
      cycle(vecs[i].v, vecs[i].c, vecs[i].clr);
      chk($sformatf("vec%0d.index", i), int'(idx_h), vecs[i].idx);
      chk($sformatf("vec%0d.index_valid", i), int'(iv_h), int'(vecs[i].iv));
      chk($sformatf("vec%0d.illegal", i), int'(ill_h), int'(vecs[i].ill));
      chk($sformatf("vec%0d.seq_err", i), int'(se_h), int'(vecs[i].se));
      chk($sformatf("vec%0d.locked", i), int'(lk_h), int'(vecs[i].lk));
      chk($sformatf("vec%0d.err_cnt", i), int'(cnt_h), vecs[i].cnt);
    end

    // Walk to the end of the ring, then two full laps including the wrap.
    cycle(1, 4'b0111, 1);
    cycle(1, 4'b0011, 0);
    cycle(1, 4'b0001, 0);
    for (int i = 0; i < 16; i++) begin
      cycle(1, jcode(i % 8), 0);
      chk("ring.index", int'(idx_h), i % 8);
      chk("ring.seq_err", int'(se_h), 0);
      chk("ring.locked", int'(lk_h), 1);
    end
    chk("ring.err_cnt", int'(cnt_h), 0);

    // Hold: 1111 repeated three times while locked.
    for (int i = 0; i < 4; i++) cycle(1, jcode(i), 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 4'b1111, 0);
      chk("hold.index", int'(idx_h), 4);
      chk("hold.seq_err", int'(se_h), 0);
      chk("nohold.seq_err", int'(se_n), (i == 1) ? 1 : 0);
    end
    chk("hold.err_cnt", int'(cnt_h), 0);

    // Counter saturation, then clear racing an illegal sample.
    for (int i = 0; i < 300; i++) cycle(1, 4'b1010, 0);
    chk("sat.err_cnt", int'(cnt_h), 255);
    chk("sat.n_err_cnt", int'(cnt_n), 255);
    cycle(1, 4'b0110, 1);
    chk("clr.err_cnt", int'(cnt_h), 0);
    chk("clr.illegal", int'(ill_h), 1);

    // Randomised stream against the models.
    gpos = 0;
    for (int t = 0; t < 2000; t++) begin
      r = $urandom_range(0, 99);
      v = 1'b1;
      clr = ($urandom_range(0, 49) == 0);
      if (r < 60) begin
        gpos = (gpos + 1) % 8;
        c = jcode(gpos);
      end else if (r < 70) begin
        c = jcode(gpos);
      end else if (r < 80) begin
        gpos = $urandom_range(0, 7);
        c = jcode(gpos);
      end else if (r < 90) begin
        c = 4'($urandom_range(0, 15));
      end else begin
        v = 1'b0;
        c = 4'($urandom_range(0, 15));
      end
      cycle(v, c, clr);
    end

    // Mid-run reset, away from any clock edge.
    for (int i = 0; i < 4; i++) cycle(1, jcode(i), 0);
    cycle(1, 4'b1010, 0);
    #2;
    reset = 1'b0; in_valid = 1'b0; clear_err = 1'b0;
    #1;
    chk_all_zero("async_reset");
    m_h = model_reset();
    m_n = model_reset();
    @(negedge clock);
    reset = 1'b1;
    cycle(1, 4'b1000, 0);
    cycle(1, 4'b1100, 0);
    chk("post_reset.locked", int'(lk_h), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
